// File: rtl/pll_lock_supervisor_pkg.sv
// State encoding and sizing helpers shared by the PLL lock supervisor files.
package pll_lock_supervisor_pkg;

    localparam int W_STATE = 3;

    localparam logic [W_STATE-1:0] PLL_RST   = 3'd0;
    localparam logic [W_STATE-1:0] WAIT_LOCK = 3'd1;
    localparam logic [W_STATE-1:0] STABLE    = 3'd2;
    localparam logic [W_STATE-1:0] RELEASE   = 3'd3;
    localparam logic [W_STATE-1:0] RUN       = 3'd4;
    localparam logic [W_STATE-1:0] FAIL      = 3'd5;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int width_of(input int value);
        return (value < 2) ? 1 : $clog2(value);
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync.sv
// Multi-flop synchroniser bringing the asynchronous PLL LOCK into the clk domain.
module sync_1bit #(
    parameter int N_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N_STAGES-1:0] stages_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stages_reg <= '0;
        end else begin
            stages_reg <= {stages_reg[N_STAGES-2:0], d};
        end
    end

    assign q = stages_reg[N_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences PLL reset, qualifies lock, releases downstream
// resets in staggered order, and recovers from lock loss or lock timeout.
module pll_lock_supervisor #(
    parameter int N_CHAN              = 3,
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES      = 8,
    parameter int MAX_RETRIES         = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              force_relock,
    output logic              pll_rst,
    output logic [N_CHAN-1:0] chan_rst_n,
    output logic              pll_ok,
    output logic              fail,
    output logic [7:0]        loss_count
);

    import pll_lock_supervisor_pkg::*;

    localparam int TW = width_of(max_of(max_of(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                        max_of(LOCK_STABLE_CYCLES, STAGGER_CYCLES)));
    localparam int RW = width_of(MAX_RETRIES + 1);
    localparam int IW = width_of(N_CHAN);

    localparam logic [TW-1:0] RST_LAST     = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] STAGGER_LAST = TW'(STAGGER_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);
    localparam logic [IW-1:0] IDX_LAST     = IW'(N_CHAN - 1);

    logic               locked_s;
    logic [W_STATE-1:0] state_reg, state_next;
    logic [TW-1:0]      timer_reg, timer_next;
    logic [RW-1:0]      retries_reg, retries_next;
    logic [IW-1:0]      idx_reg, idx_next;
    logic [7:0]         loss_reg, loss_next;
    logic [N_CHAN-1:0]  chan_next;
    logic [N_CHAN-1:0]  chan_reg;
    logic               releasing;
    logic               pll_rst_reg, pll_ok_reg, fail_reg;

    sync_1bit #(.N_STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        retries_next = retries_reg;
        idx_next     = idx_reg;
        loss_next    = loss_reg;
        case (state_reg)
            PLL_RST: begin
                idx_next = '0;
                if (force_relock) begin
                    timer_next = '0;
                end else if (timer_reg == RST_LAST) begin
                    state_next = WAIT_LOCK;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (force_relock) begin
                    state_next = PLL_RST;
                    timer_next = '0;
                end else if (locked_s) begin
                    // The cycle lock is first seen is the first cycle of the stable window.
                    state_next = STABLE;
                    timer_next = TW'(1);
                end else if (timer_reg == TIMEOUT_LAST) begin
                    timer_next = '0;
                    if (retries_reg == RETRY_LIMIT) begin
                        state_next = FAIL;
                    end else begin
                        retries_next = retries_reg + 1'b1;
                        state_next   = PLL_RST;
                    end
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            STABLE: begin
                if (force_relock) begin
                    state_next = PLL_RST;
                    timer_next = '0;
                end else if (!locked_s) begin
                    state_next = WAIT_LOCK;
                    timer_next = '0;
                end else if (timer_reg >= STABLE_LAST) begin
                    state_next = RELEASE;
                    timer_next = '0;
                    idx_next   = '0;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            RELEASE, RUN: begin
                if (force_relock || !locked_s) begin
                    state_next = PLL_RST;
                    timer_next = '0;
                    idx_next   = '0;
                    if (!locked_s && loss_reg != 8'hFF) begin
                        loss_next = loss_reg + 8'd1;
                    end
                end else if (state_reg == RELEASE) begin
                    if (idx_reg == IDX_LAST) begin
                        state_next = RUN;
                    end else if (timer_reg == STAGGER_LAST) begin
                        timer_next = '0;
                        idx_next   = idx_reg + 1'b1;
                    end else begin
                        timer_next = timer_reg + 1'b1;
                    end
                end
            end
            FAIL: begin
                state_next = FAIL;
            end
            default: begin
                state_next = PLL_RST;
                timer_next = '0;
                idx_next   = '0;
            end
        endcase
        // A fully released tree means this attempt succeeded; forget earlier timeouts.
        if (state_next == RELEASE && idx_next == IDX_LAST) begin
            retries_next = '0;
        end
    end

    assign releasing = (state_next == RELEASE) || (state_next == RUN);

    // Released channels form a thermometer code up to the stagger index.
    generate
        for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_chan
            assign chan_next[gi] = releasing && (idx_next >= IW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= PLL_RST;
            timer_reg   <= '0;
            retries_reg <= '0;
            idx_reg     <= '0;
            loss_reg    <= '0;
            chan_reg    <= '0;
            pll_rst_reg <= 1'b1;
            pll_ok_reg  <= 1'b0;
            fail_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            retries_reg <= retries_next;
            idx_reg     <= idx_next;
            loss_reg    <= loss_next;
            chan_reg    <= chan_next;
            pll_rst_reg <= (state_next == PLL_RST) || (state_next == FAIL);
            pll_ok_reg  <= releasing && (idx_next == IDX_LAST);
            fail_reg    <= (state_next == FAIL);
        end
    end

    assign pll_rst    = pll_rst_reg;
    assign chan_rst_n = chan_reg;
    assign pll_ok     = pll_ok_reg;
    assign fail       = fail_reg;
    assign loss_count = loss_reg;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed scenarios for pll_lock_supervisor; expected output vectors are queued per cycle
// and a negedge monitor compares them against the DUT.
module tb_pll_lock_supervisor;

    localparam int N_CHAN = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pll_locked = 1'b0;
    logic              force_relock = 1'b0;
    logic              pll_rst;
    logic [N_CHAN-1:0] chan_rst_n;
    logic              pll_ok;
    logic              fail;
    logic [7:0]        loss_count;

    int cyc = 0;
    int n_vec = 0;
    int n_miss = 0;

    typedef struct {
        int          cyc;
        logic [13:0] val;
    } exp_t;

    exp_t  sb[$];
    string tag_q[$];

    pll_lock_supervisor #(
        .N_CHAN              (3),
        .SYNC_STAGES         (2),
        .PLL_RST_CYCLES      (4),
        .LOCK_TIMEOUT_CYCLES (32),
        .LOCK_STABLE_CYCLES  (16),
        .STAGGER_CYCLES      (2),
        .MAX_RETRIES         (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .force_relock (force_relock),
        .pll_rst      (pll_rst),
        .chan_rst_n   (chan_rst_n),
        .pll_ok       (pll_ok),
        .fail         (fail),
        .loss_count   (loss_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic expect_at(input int c, input logic pr, input logic [2:0] ch,
                             input logic ok, input logic fl, input int loss, input string tag);
        exp_t e;
        e.cyc = c;
        e.val = {pr, ch, ok, fl, 8'(loss)};
        sb.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic do_reset(output int base);
        rst_n = 1'b0;
        force_relock = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        base = cyc;
    endtask

    // Monitor: compare every queued vector in the cycle it is due.
    always @(negedge clk) begin
        logic [13:0] got;
        exp_t        e;
        string       tag;
        got = {pll_rst, chan_rst_n, pll_ok, fail, loss_count};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            tag = tag_q.pop_front();
            n_vec++;
            if (e.cyc < cyc) begin
                n_miss++;
                $display("FAIL %s cyc=%0d not sampled in time (now %0d)", tag, e.cyc, cyc);
            end else if (got !== e.val) begin
                n_miss++;
                $display("FAIL %s cyc=%0d got pll_rst=%b chan_rst_n=%b pll_ok=%b fail=%b loss=%0d want pll_rst=%b chan_rst_n=%b pll_ok=%b fail=%b loss=%0d",
                         tag, cyc, got[13], got[12:10], got[9], got[8], got[7:0],
                         e.val[13], e.val[12:10], e.val[9], e.val[8], e.val[7:0]);
            end else begin
                $display("ok   %s cyc=%0d pll_rst=%b chan_rst_n=%b pll_ok=%b fail=%b loss=%0d",
                         tag, cyc, got[13], got[12:10], got[9], got[8], got[7:0]);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int k;
        int sat;

        // Clean power-up, lock at cycle 10, then a one-cycle lock drop in RUN.
        pll_locked = 1'b0;
        do_reset(b);
        expect_at(b + 0,  1'b1, 3'b000, 1'b0, 1'b0, 0, "s1_reset");
        expect_at(b + 3,  1'b1, 3'b000, 1'b0, 1'b0, 0, "s1_rst_last");
        expect_at(b + 4,  1'b0, 3'b000, 1'b0, 1'b0, 0, "s1_rst_done");
        expect_at(b + 27, 1'b0, 3'b000, 1'b0, 1'b0, 0, "s1_pre_release");
        expect_at(b + 28, 1'b0, 3'b001, 1'b0, 1'b0, 0, "s1_chan0");
        expect_at(b + 29, 1'b0, 3'b001, 1'b0, 1'b0, 0, "s1_chan0_hold");
        expect_at(b + 30, 1'b0, 3'b011, 1'b0, 1'b0, 0, "s1_chan1");
        expect_at(b + 31, 1'b0, 3'b011, 1'b0, 1'b0, 0, "s1_chan1_hold");
        expect_at(b + 32, 1'b0, 3'b111, 1'b1, 1'b0, 0, "s1_pll_ok");
        expect_at(b + 42, 1'b0, 3'b111, 1'b1, 1'b0, 0, "s3_before_loss");
        expect_at(b + 43, 1'b1, 3'b000, 1'b0, 1'b0, 1, "s3_loss");
        expect_at(b + 46, 1'b1, 3'b000, 1'b0, 1'b0, 1, "s3_rst_last");
        expect_at(b + 47, 1'b0, 3'b000, 1'b0, 1'b0, 1, "s3_rst_done");
        expect_at(b + 62, 1'b0, 3'b000, 1'b0, 1'b0, 1, "s3_pre_release");
        expect_at(b + 63, 1'b0, 3'b001, 1'b0, 1'b0, 1, "s3_chan0");
        expect_at(b + 65, 1'b0, 3'b011, 1'b0, 1'b0, 1, "s3_chan1");
        expect_at(b + 67, 1'b0, 3'b111, 1'b1, 1'b0, 1, "s3_pll_ok");
        run_to(b + 10); pll_locked = 1'b1;
        run_to(b + 40); pll_locked = 1'b0;
        run_to(b + 41); pll_locked = 1'b1;
        run_to(b + 70);

        // No lock ever: three reset pulses, then sticky fail.
        pll_locked = 1'b0;
        do_reset(b);
        expect_at(b + 0,   1'b1, 3'b000, 1'b0, 1'b0, 0, "s2_reset");
        expect_at(b + 3,   1'b1, 3'b000, 1'b0, 1'b0, 0, "s2_rst_last");
        expect_at(b + 4,   1'b0, 3'b000, 1'b0, 1'b0, 0, "s2_wait1");
        expect_at(b + 35,  1'b0, 3'b000, 1'b0, 1'b0, 0, "s2_timeout1");
        expect_at(b + 36,  1'b1, 3'b000, 1'b0, 1'b0, 0, "s2_retry1");
        expect_at(b + 39,  1'b1, 3'b000, 1'b0, 1'b0, 0, "s2_retry1_last");
        expect_at(b + 40,  1'b0, 3'b000, 1'b0, 1'b0, 0, "s2_wait2");
        expect_at(b + 71,  1'b0, 3'b000, 1'b0, 1'b0, 0, "s2_timeout2");
        expect_at(b + 72,  1'b1, 3'b000, 1'b0, 1'b0, 0, "s2_retry2");
        expect_at(b + 75,  1'b1, 3'b000, 1'b0, 1'b0, 0, "s2_retry2_last");
        expect_at(b + 76,  1'b0, 3'b000, 1'b0, 1'b0, 0, "s2_wait3");
        expect_at(b + 107, 1'b0, 3'b000, 1'b0, 1'b0, 0, "s2_pre_fail");
        expect_at(b + 108, 1'b1, 3'b000, 1'b0, 1'b1, 0, "s2_fail");
        expect_at(b + 130, 1'b1, 3'b000, 1'b0, 1'b1, 0, "s2_fail_toggle");
        expect_at(b + 150, 1'b1, 3'b000, 1'b0, 1'b1, 0, "s2_fail_force");
        expect_at(b + 165, 1'b1, 3'b000, 1'b0, 1'b1, 0, "s2_fail_locked");
        run_to(b + 110);
        for (int i = 0; i < 50; i++) begin
            pll_locked = ~pll_locked;
            force_relock = (cyc == b + 140);
            tick();
        end
        force_relock = 1'b0;
        pll_locked = 1'b1;
        run_to(b + 170);

        // Lock lost at stable count 10: window restarts, nothing counted.
        pll_locked = 1'b1;
        do_reset(b);
        expect_at(b + 0,  1'b1, 3'b000, 1'b0, 1'b0, 0, "s4_fail_cleared");
        expect_at(b + 14, 1'b0, 3'b000, 1'b0, 1'b0, 0, "s4_no_retry");
        expect_at(b + 20, 1'b0, 3'b000, 1'b0, 1'b0, 0, "s4_no_release");
        expect_at(b + 29, 1'b0, 3'b000, 1'b0, 1'b0, 0, "s4_window");
        expect_at(b + 30, 1'b0, 3'b001, 1'b0, 1'b0, 0, "s4_chan0");
        expect_at(b + 34, 1'b0, 3'b111, 1'b1, 1'b0, 0, "s4_pll_ok");
        run_to(b + 11); pll_locked = 1'b0;
        run_to(b + 12); pll_locked = 1'b1;
        run_to(b + 36);

        // force_relock in RELEASE, alone and together with a lock drop.
        do_reset(b);
        expect_at(b + 20, 1'b0, 3'b001, 1'b0, 1'b0, 0, "s5_chan0");
        expect_at(b + 21, 1'b1, 3'b000, 1'b0, 1'b0, 0, "s5_force");
        expect_at(b + 24, 1'b1, 3'b000, 1'b0, 1'b0, 0, "s5_rst_last");
        expect_at(b + 25, 1'b0, 3'b000, 1'b0, 1'b0, 0, "s5_rst_done");
        expect_at(b + 40, 1'b0, 3'b000, 1'b0, 1'b0, 0, "s5_pre_release");
        expect_at(b + 41, 1'b0, 3'b001, 1'b0, 1'b0, 0, "s5_chan0_again");
        expect_at(b + 42, 1'b1, 3'b000, 1'b0, 1'b0, 1, "s5_force_and_loss");
        expect_at(b + 62, 1'b0, 3'b001, 1'b0, 1'b0, 1, "s5_chan0_third");
        expect_at(b + 66, 1'b0, 3'b111, 1'b1, 1'b0, 1, "s5_pll_ok");
        run_to(b + 20); force_relock = 1'b1;
        run_to(b + 21); force_relock = 1'b0;
        run_to(b + 39); pll_locked = 1'b0;
        run_to(b + 40); pll_locked = 1'b1;
        run_to(b + 41); force_relock = 1'b1;
        run_to(b + 42); force_relock = 1'b0;
        run_to(b + 68);

        // 256 lock losses saturate the counter; then reset mid-RELEASE.
        do_reset(b);
        expect_at(b + 24, 1'b0, 3'b111, 1'b1, 1'b0, 0, "s6_up");
        for (int n = 1; n <= 256; n++) begin
            if (n == 1 || n == 2 || n == 255 || n == 256) begin
                k = b + 30 * n;
                sat = (n > 255) ? 255 : n;
                if (n == 256)
                    expect_at(k + 2, 1'b0, 3'b111, 1'b1, 1'b0, 255, "s6_pre256");
                expect_at(k + 3,  1'b1, 3'b000, 1'b0, 1'b0, sat, $sformatf("s6_loss%0d", n));
                expect_at(k + 27, 1'b0, 3'b111, 1'b1, 1'b0, sat, $sformatf("s6_relock%0d", n));
            end
        end
        k = b + 30 * 257;
        expect_at(k + 23, 1'b0, 3'b001, 1'b0, 1'b0, 255, "s6_mid_release");
        expect_at(k + 25, 1'b1, 3'b000, 1'b0, 1'b0, 0,   "s6_reset_values");
        expect_at(k + 45, 1'b0, 3'b001, 1'b0, 1'b0, 0,   "s6_restart_chan0");
        expect_at(k + 49, 1'b0, 3'b111, 1'b1, 1'b0, 0,   "s6_restart_ok");
        for (int n = 1; n <= 257; n++) begin
            run_to(b + 30 * n);
            pll_locked = 1'b0;
            tick();
            pll_locked = 1'b1;
        end
        run_to(k + 24); rst_n = 1'b0;
        run_to(k + 25); rst_n = 1'b1;
        run_to(k + 52);

        if (sb.size() != 0) begin
            $display("FAIL leftover %0d expected vectors never compared", sb.size());
            n_miss += sb.size();
            n_vec  += sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
